// File: rtl/johnson_decoder.sv
// Johnson code checker/decoder: decodes a WIDTH-bit twisted-ring word to a phase index,
// flags illegal words and out-of-sequence steps, and locks onto a clean stream.
// Latency 1 cycle (all outputs registered); no backpressure, sampled when code_valid.
// Optional JDEC_HOLD_EN: a repeated index (stalled counter) is accepted silently.
module johnson_decoder #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8,
   localparam int IW      = $clog2(2*WIDTH),
   localparam int MW      = $clog2(LOCK_CNT+1)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] code_in,
   input  logic             code_valid,
   output logic [IW-1:0]    index,
   output logic             index_valid,
   output logic             illegal,
   output logic             seq_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

   localparam logic [IW:0]    SEQ_LEN  = (IW+1)'(2*WIDTH);
   localparam logic [IW-1:0]  LAST_IDX = IW'(2*WIDTH-1);
   localparam logic [MW-1:0]  LOCK_M   = MW'(LOCK_CNT);

   state_t           state;
   logic             prev_ok;
   logic             miss;
   logic [MW-1:0]    match_cnt;

   logic [WIDTH-1:0] ncode;
   logic             legal;
   logic [IW:0]      pcnt;
   logic [IW:0]      dec_w;
   logic [IW-1:0]    dec_idx;
   logic [IW-1:0]    succ_idx;
   logic             is_succ;
   logic             hold_hit;
   logic [MW-1:0]    match_inc;

   always_comb begin
      ncode = ~code_in;
      // 0..01..1 has no carry overlap with its increment; 1..10..0 is its complement
      legal = ((code_in & (code_in + WIDTH'(1))) == '0) ||
              ((ncode & (ncode + WIDTH'(1))) == '0);
      pcnt = '0;
      for (int i = 0; i < WIDTH; i++)
         pcnt = pcnt + {{IW{1'b0}}, code_in[i]};
      dec_w    = code_in[WIDTH-1] ? (SEQ_LEN - pcnt) : pcnt;
      dec_idx  = dec_w[IW-1:0];
      succ_idx = (index == LAST_IDX) ? '0 : index + IW'(1);
      is_succ  = (dec_idx == succ_idx);
      match_inc = (match_cnt == LOCK_M) ? match_cnt : match_cnt + MW'(1);
   end

`ifdef JDEC_HOLD_EN
   assign hold_hit = (dec_idx == index);
`else
   assign hold_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state       <= UNLOCKED;
         prev_ok     <= 1'b0;
         miss        <= 1'b0;
         match_cnt   <= '0;
         index       <= '0;
         index_valid <= 1'b0;
         illegal     <= 1'b0;
         seq_err     <= 1'b0;
         locked      <= 1'b0;
         err_count   <= '0;
      end else begin
         index_valid <= 1'b0;
         illegal     <= 1'b0;
         seq_err     <= 1'b0;
         if (code_valid) begin
            if (!legal) begin
               illegal   <= 1'b1;
               prev_ok   <= 1'b0;
               miss      <= 1'b0;
               match_cnt <= '0;
               state     <= UNLOCKED;
               locked    <= 1'b0;
               if (err_count != '1)
                  err_count <= err_count + ERR_W'(1);
            end else begin
               index       <= dec_idx;
               index_valid <= 1'b1;
               prev_ok     <= 1'b1;
               if (!prev_ok) begin
                  if (state == UNLOCKED)
                     state <= LOCKING;
               end else if (hold_hit) begin
                  // stalled generator: nothing to learn from this word
               end else if (is_succ) begin
                  match_cnt <= match_inc;
                  miss      <= 1'b0;
                  if (state == LOCKED || match_inc == LOCK_M) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end else begin
                     state <= LOCKING;
                  end
               end else begin
                  seq_err   <= 1'b1;
                  match_cnt <= '0;
                  if (err_count != '1)
                     err_count <= err_count + ERR_W'(1);
                  // one slip is tolerated while locked; a second in a row drops lock
                  if (state == LOCKED) begin
                     if (miss) begin
                        state  <= UNLOCKED;
                        locked <= 1'b0;
                        miss   <= 1'b0;
                     end else begin
                        miss <= 1'b1;
                     end
                  end else if (state == UNLOCKED) begin
                     state <= LOCKING;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder (WIDTH=4): vector table through a scoreboard queue,
// plus hand sequences for error-counter saturation and asynchronous reset.
module tb_johnson_decoder;

   typedef struct packed {
      logic [2:0] idx;
      logic       iv;
      logic       ill;
      logic       se;
      logic       lk;
      logic [7:0] err;
   } out_t;

   typedef struct packed {
      logic [3:0] code;
      logic       vld;
      out_t       exp;
   } vec_t;

`ifdef JDEC_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr_n;
   logic [3:0] code_in;
   logic       code_valid;
   logic [2:0] index;
   logic       index_valid;
   logic       illegal;
   logic       seq_err;
   logic       locked;
   logic [7:0] err_count;

   int   tests  = 0;
   int   failed = 0;
   out_t sb[$];
   vec_t tbl[26];

   johnson_decoder dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .code_in    (code_in),
      .code_valid (code_valid),
      .index      (index),
      .index_valid(index_valid),
      .illegal    (illegal),
      .seq_err    (seq_err),
      .locked     (locked),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [3:0] c, input logic v, input logic [2:0] i,
                               input logic iv, input logic il, input logic se,
                               input logic lk, input logic [7:0] e);
      vec_t r;
      r.code = c; r.vld = v;
      r.exp.idx = i; r.exp.iv = iv; r.exp.ill = il; r.exp.se = se; r.exp.lk = lk;
      r.exp.err = e;
      return r;
   endfunction

   task automatic cmp(input string name, input out_t e);
      out_t g;
      g = '{index, index_valid, illegal, seq_err, locked, err_count};
      tests++;
      if (g !== e || (illegal && seq_err)) begin
         failed++;
         $display("FAIL %s: got idx=%0d iv=%0b ill=%0b se=%0b lk=%0b err=%0d, want idx=%0d iv=%0b ill=%0b se=%0b lk=%0b err=%0d",
                  name, g.idx, g.iv, g.ill, g.se, g.lk, g.err,
                  e.idx, e.iv, e.ill, e.se, e.lk, e.err);
      end
   endtask

   // drive one word, queue its expectation, compare once the registered result appears
   task automatic step(input string name, input logic [3:0] c, input logic v, input out_t e);
      code_in    = c;
      code_valid = v;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         tests++; failed++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         cmp(name, sb.pop_front());
      end
   endtask

   initial begin
      out_t e;
      int   err0;

      // T2 clean stream, valid gap, T3 wrap
      tbl[0]  = mk(4'b1000, 1, 3'd7, 1, 0, 0, 0, 8'd0);
      tbl[1]  = mk(4'b0000, 1, 3'd0, 1, 0, 0, 0, 8'd0);
      tbl[2]  = mk(4'b0001, 1, 3'd1, 1, 0, 0, 0, 8'd0);
      tbl[3]  = mk(4'b0011, 1, 3'd2, 1, 0, 0, 1, 8'd0);
      tbl[4]  = mk(4'b0111, 1, 3'd3, 1, 0, 0, 1, 8'd0);
      tbl[5]  = mk(4'b1111, 1, 3'd4, 1, 0, 0, 1, 8'd0);
      tbl[6]  = mk(4'b1110, 1, 3'd5, 1, 0, 0, 1, 8'd0);
      tbl[7]  = mk(4'b0101, 0, 3'd5, 0, 0, 0, 1, 8'd0);
      tbl[8]  = mk(4'b1100, 1, 3'd6, 1, 0, 0, 1, 8'd0);
      tbl[9]  = mk(4'b1000, 1, 3'd7, 1, 0, 0, 1, 8'd0);
      tbl[10] = mk(4'b0000, 1, 3'd0, 1, 0, 0, 1, 8'd0);
      // T4 illegal while locked, then relock
      tbl[11] = mk(4'b0101, 1, 3'd0, 0, 1, 0, 0, 8'd1);
      tbl[12] = mk(4'b0001, 1, 3'd1, 1, 0, 0, 0, 8'd1);
      tbl[13] = mk(4'b0011, 1, 3'd2, 1, 0, 0, 0, 8'd1);
      tbl[14] = mk(4'b0111, 1, 3'd3, 1, 0, 0, 0, 8'd1);
      tbl[15] = mk(4'b1111, 1, 3'd4, 1, 0, 0, 1, 8'd1);
      tbl[16] = mk(4'b1110, 1, 3'd5, 1, 0, 0, 1, 8'd1);
      tbl[17] = mk(4'b1100, 1, 3'd6, 1, 0, 0, 1, 8'd1);
      tbl[18] = mk(4'b1000, 1, 3'd7, 1, 0, 0, 1, 8'd1);
      tbl[19] = mk(4'b0000, 1, 3'd0, 1, 0, 0, 1, 8'd1);
      // T5 single skip keeps lock, second consecutive skip drops it
      tbl[20] = mk(4'b0001, 1, 3'd1, 1, 0, 0, 1, 8'd1);
      tbl[21] = mk(4'b0111, 1, 3'd3, 1, 0, 1, 1, 8'd2);
      tbl[22] = mk(4'b0000, 1, 3'd0, 1, 0, 1, 0, 8'd3);
      // T6 repeat after a fresh start
      tbl[23] = mk(4'b1010, 1, 3'd0, 0, 1, 0, 0, 8'd4);
      tbl[24] = mk(4'b0011, 1, 3'd2, 1, 0, 0, 0, 8'd4);
      tbl[25] = mk(4'b0011, 1, 3'd2, 1, 0, !HOLD, 0, HOLD ? 8'd4 : 8'd5);

      clr_n      = 1'b0;
      code_in    = 4'b0000;
      code_valid = 1'b0;
      #12;
      cmp("reset_state", '0);
      @(negedge clk);
      clr_n = 1'b1;

      for (int i = 0; i < 26; i++)
         step($sformatf("vec%0d", i), tbl[i].code, tbl[i].vld, tbl[i].exp);

      // saturating error counter: 256 illegal words
      err0 = HOLD ? 4 : 5;
      for (int k = 1; k <= 256; k++) begin
         e = '{3'd2, 1'b0, 1'b1, 1'b0, 1'b0, ((err0 + k) > 255) ? 8'hFF : 8'(err0 + k)};
         step($sformatf("sat%0d", k), 4'b0110, 1'b1, e);
      end

      // relock, then T1 asynchronous reset mid-stream
      step("relock0", 4'b0001, 1'b1, '{3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF});
      step("relock1", 4'b0011, 1'b1, '{3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF});
      step("relock2", 4'b0111, 1'b1, '{3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF});
      step("relock3", 4'b1111, 1'b1, '{3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF});
      code_in = 4'b1110;
      #2;
      clr_n = 1'b0;
      #1;
      cmp("async_reset", '0);
      @(posedge clk);
      #1;
      cmp("reset_hold", '0);
      #2;
      clr_n = 1'b1;
      @(negedge clk);
      step("post_reset", 4'b0000, 1'b1, '{3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
      step("post_idle", 4'b0001, 1'b0, '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});

      if (sb.size() != 0) begin
         tests++; failed++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
